// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore main control FSM for a multicycle MIPS-32 datapath
module multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [5:0]       op,
    output logic             iord,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic             pc_write,
    output logic             branch,
    output logic             halted,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTE  = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_ADDIEX   = 4'd9;
    localparam logic [3:0] S_ADDIWB   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;
    localparam logic [3:0] S_HALT     = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [3:0] state_next;
    logic       retiring;

    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXECUTE;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JUMP;
                    default:      state_next = S_HALT;
                endcase
            end
            // IR is held stable, so op still names the memory instruction here
            S_MEMADR: begin
                if (op == OP_LW)
                    state_next = S_MEMREAD;
                else if (op == OP_SW)
                    state_next = S_MEMWRITE;
                else
                    state_next = S_HALT;
            end
            S_MEMREAD: state_next = S_MEMWB;
            S_EXECUTE: state_next = S_ALUWB;
            S_ADDIEX:  state_next = S_ADDIWB;
            S_MEMWB, S_MEMWRITE, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP:
                       state_next = S_FETCH;
            S_HALT:    state_next = S_HALT;
            default:   state_next = S_FETCH;
        endcase
    end

    always_comb begin
        retiring = 1'b0;
        case (state)
            S_MEMWB, S_MEMWRITE, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: retiring = 1'b1;
            default: retiring = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_FETCH;
            retired <= '0;
            halted  <= 1'b0;
        end else if (en) begin
            state <= state_next;
            if (retiring)
                retired <= retired + CNT_W'(1);
            if (state_next == S_HALT)
                halted <= 1'b1;
        end
    end

    always_comb begin
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        pc_write   = 1'b0;
        branch     = 1'b0;
        case (state)
            S_FETCH:    begin ir_write = 1'b1; pc_write = 1'b1; alu_src_b = 2'b01; end
            S_DECODE:   alu_src_b = 2'b11;
            S_MEMADR:   begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
            S_MEMREAD:  iord = 1'b1;
            S_MEMWB:    begin mem_to_reg = 1'b1; reg_write = 1'b1; end
            S_MEMWRITE: begin iord = 1'b1; mem_write = 1'b1; end
            S_EXECUTE:  begin alu_src_a = 1'b1; alu_op = 2'b10; end
            S_ALUWB:    begin reg_dst = 1'b1; reg_write = 1'b1; end
            S_BRANCH:   begin alu_src_a = 1'b1; alu_op = 2'b01; pc_src = 2'b01; branch = 1'b1; end
            S_ADDIEX:   begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
            S_ADDIWB:   reg_write = 1'b1;
            S_JUMP:     begin pc_src = 2'b10; pc_write = 1'b1; end
            default:    ;
        endcase
        // a stall must never commit architectural state, selects stay put
        if (!en) begin
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            branch    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b1;
    logic [5:0]  op = 6'b000000;

    logic        iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_src;
    logic        pc_write, branch, halted;
    logic [3:0]  state;
    logic [31:0] retired;

    logic        iord2, mem_write2, ir_write2, reg_dst2, mem_to_reg2, reg_write2, alu_src_a2;
    logic [1:0]  alu_src_b2, alu_op2, pc_src2;
    logic        pc_write2, branch2, halted2;
    logic [3:0]  state2;
    logic [1:0]  retired2;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [3:0]  st;
        logic        hl;
        logic [31:0] ret;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .en(en), .op(op),
        .iord(iord), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .pc_write(pc_write),
        .branch(branch), .halted(halted), .state(state), .retired(retired)
    );

    multicycle_controller #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .en(en), .op(op),
        .iord(iord2), .mem_write(mem_write2), .ir_write(ir_write2), .reg_dst(reg_dst2),
        .mem_to_reg(mem_to_reg2), .reg_write(reg_write2), .alu_src_a(alu_src_a2),
        .alu_src_b(alu_src_b2), .alu_op(alu_op2), .pc_src(pc_src2), .pc_write(pc_write2),
        .branch(branch2), .halted(halted2), .state(state2), .retired(retired2)
    );

    // {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
    //  alu_src_b, alu_op, pc_src, pc_write, branch}
    function automatic logic [14:0] exp_ctrl(input logic [3:0] st, input logic e);
        logic io, mw, iw, rd, mr, rw, sa, pw, br;
        logic [1:0] sb, ao, ps;
        {io, mw, iw, rd, mr, rw, sa, pw, br} = '0;
        sb = 2'b00; ao = 2'b00; ps = 2'b00;
        case (st)
            4'd0:  begin iw = 1; pw = 1; sb = 2'b01; end
            4'd1:  sb = 2'b11;
            4'd2:  begin sa = 1; sb = 2'b10; end
            4'd3:  io = 1;
            4'd4:  begin mr = 1; rw = 1; end
            4'd5:  begin io = 1; mw = 1; end
            4'd6:  begin sa = 1; ao = 2'b10; end
            4'd7:  begin rd = 1; rw = 1; end
            4'd8:  begin sa = 1; ao = 2'b01; ps = 2'b01; br = 1; end
            4'd9:  begin sa = 1; sb = 2'b10; end
            4'd10: rw = 1;
            4'd11: begin ps = 2'b10; pw = 1; end
            default: ;
        endcase
        if (!e) begin
            iw = 0; pw = 0; mw = 0; rw = 0; br = 0;
        end
        return {io, mw, iw, rd, mr, rw, sa, sb, ao, ps, pw, br};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic compare(input string tag);
        exp_t e;
        logic [14:0] ctrl;
        e = exp_q.pop_front();
        ctrl = {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                alu_src_b, alu_op, pc_src, pc_write, branch};
        chk({tag, ":state"}, {28'd0, state}, {28'd0, e.st});
        chk({tag, ":ctrl"}, {17'd0, ctrl}, {17'd0, exp_ctrl(e.st, en)});
        chk({tag, ":halted"}, {31'd0, halted}, {31'd0, e.hl});
        chk({tag, ":retired"}, retired, e.ret);
    endtask

    task automatic push(input logic [3:0] st, input logic hl, input logic [31:0] ret);
        exp_t e;
        e.st = st; e.hl = hl; e.ret = ret;
        exp_q.push_back(e);
    endtask

    task automatic tick(input logic [3:0] st, input logic hl, input logic [31:0] ret,
                        input string tag);
        push(st, hl, ret);
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    task automatic look(input logic [3:0] st, input logic hl, input logic [31:0] ret,
                        input string tag);
        push(st, hl, ret);
        #1;
        compare(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        en = 1'b1;
        tick(4'd0, 1'b0, 32'd0, "reset");
        reset = 1'b0;
    endtask

    initial begin
        #2;
        do_reset();

        // lw: 0,1,2,3,4,0
        op = 6'b100011;
        tick(4'd1, 0, 0, "lw");
        tick(4'd2, 0, 0, "lw");
        tick(4'd3, 0, 0, "lw");
        tick(4'd4, 0, 0, "lw");
        tick(4'd0, 0, 1, "lw");

        // R-type then beq
        do_reset();
        op = 6'b000000;
        tick(4'd1, 0, 0, "rtype");
        tick(4'd6, 0, 0, "rtype");
        tick(4'd7, 0, 0, "rtype");
        tick(4'd0, 0, 1, "rtype");
        op = 6'b000100;
        tick(4'd1, 0, 1, "beq");
        tick(4'd8, 0, 1, "beq");
        tick(4'd0, 0, 2, "beq");

        // sw stalled in MEMWRITE
        do_reset();
        op = 6'b101011;
        tick(4'd1, 0, 0, "sw");
        tick(4'd2, 0, 0, "sw");
        tick(4'd5, 0, 0, "sw");
        en = 1'b0;
        look(4'd5, 0, 0, "sw_stall");
        for (int i = 0; i < 3; i++)
            tick(4'd5, 0, 0, "sw_stall");
        en = 1'b1;
        look(4'd5, 0, 0, "sw_go");
        tick(4'd0, 0, 1, "sw_go");
        tick(4'd1, 0, 1, "sw_next");

        // illegal opcode halts
        do_reset();
        op = 6'b111111;
        tick(4'd1, 0, 0, "ill");
        tick(4'd12, 1, 0, "ill_halt");
        for (int i = 0; i < 20; i++)
            tick(4'd12, 1, 0, "halt_hold");
        en = 1'b0;
        tick(4'd12, 1, 0, "halt_stall");
        en = 1'b1;
        op = 6'b000010;
        tick(4'd12, 1, 0, "halt_hold");
        do_reset();

        // reset mid-lw abandons the instruction
        op = 6'b100011;
        tick(4'd1, 0, 0, "lw1");
        tick(4'd2, 0, 0, "lw1");
        tick(4'd3, 0, 0, "lw1");
        tick(4'd4, 0, 0, "lw1");
        tick(4'd0, 0, 1, "lw1");
        tick(4'd1, 0, 1, "lw2");
        tick(4'd2, 0, 1, "lw2");
        tick(4'd3, 0, 1, "lw2");
        reset = 1'b1;
        tick(4'd0, 0, 0, "mid_reset");
        reset = 1'b0;
        tick(4'd1, 0, 0, "after_reset");

        // jumps, narrow counter wraps
        do_reset();
        op = 6'b000010;
        for (int k = 0; k < 5; k++) begin
            tick(4'd1, 0, k, "j");
            tick(4'd11, 0, k, "j");
            chk("j:pc_src", {30'd0, pc_src}, 32'd2);
            tick(4'd0, 0, k + 1, "j");
            chk("j:ret2", {30'd0, retired2}, (k + 1) % 4);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
